conv_8b_32b: RTL
================

# conv_8b_32b

Byte-to-word packer that reassembles the 8-bit stream produced by the 32b→8b serializer into 32-bit words. It runs entirely on `clk_4f`, shifts in four consecutive valid bytes most-significant-byte first, and presents each completed word with a `valid_out` window of one `clk_f` period (4 `clk_4f` cycles). It also generates the divided `clk_f` for downstream word-rate logic, and flags fragmented words.

## Interface
Parameters: none; widths are fixed (8-bit in, 32-bit out, ratio 4).

Ports:
- `clk_4f`  in  1  byte-rate clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `data_in`  in  8  byte lane from serializer
- `valid_in`  in  1  `data_in` carries a valid byte this cycle
- `data_out`  out  32  last completed word, byte 0 in [31:24]
- `valid_out`  out  1  `data_out` is a fresh word; held 4 cycles per word
- `clk_f`  out  1  `clk_4f` divided by 4, registered
- `err_frag`  out  1  one-cycle pulse: partial word discarded

## Operation
- Reset: sampled on the `clk_4f` rising edge while `reset`=1. It sets all outputs to 0 and `data_out` to 32'h0. It clears the byte counter `bcnt` (2 bit), the shift register `sreg` (24 bit), the hold counter `hcnt` (2 bit) and the divider `dcnt` (2 bit). Reset mid-word discards the partial word without pulsing `err_frag`.
- Divider: `dcnt` increments every cycle and wraps 3→0. `clk_f` = `dcnt[1]`. After reset, `clk_f` is 0 for 2 cycles, then 1 for 2 cycles, then repeats. The divider is free-running and is not realigned to word boundaries.
- States: IDLE (`bcnt`=0, no partial word), FILL (`bcnt`=1..3).
  - IDLE with `valid_in`=1: `sreg[23:16]`←`data_in`, `bcnt`←1, go to FILL.
  - FILL with `valid_in`=1 and `bcnt`<3: store the byte at the next lower lane and increment `bcnt`.
  - FILL with `valid_in`=1 and `bcnt`=3: `data_out`←{`sreg`, `data_in`}, `valid_out`←1, `hcnt`←3, `bcnt`←0, go to IDLE.
  - FILL with `valid_in`=0: discard the partial word, `bcnt`←0, `err_frag`←1 for one cycle, go to IDLE.
- Byte order: the first valid byte of a word goes to [31:24] and the fourth goes to [7:0]. A serialized 32'hFFFBBFFF (FF,FB,BF,FF) reassembles to 32'hFFFBBFFF.
- Hold: while `hcnt`>0 and no new word completes, decrement `hcnt` each cycle. When `hcnt`=0 and no completion, `valid_out`←0. `data_out` keeps its last word after `valid_out` falls and is never cleared except by reset.
- A completion on the same cycle that the hold expires reloads `hcnt`←3 and keeps `valid_out` high. Back-to-back words therefore give a continuous `valid_out` with `data_out` changing every 4 cycles.
- IDLE with `valid_in`=0: nothing changes except the divider and the hold.

## Timing
- Latency: the 4th byte is sampled at edge N. `data_out`/`valid_out` update at edge N, so they are visible in cycle N+1.
- Single isolated word: `valid_out` is high for exactly 4 cycles (after edges N..N+3) and low after edge N+4.
- `err_frag` is registered. It is high for the single cycle after the edge that sampled `valid_in`=0 in FILL.
- Throughput: one word per 4 cycles maximum; no backpressure, no stall input.
- A word never straddles a reset. Bytes are accepted on the first edge after `reset` deasserts.
- The divider phase is independent of `valid_in`, so a word may complete at any `dcnt` value.

## Test plan
- Reset: hold `reset` 3 cycles with `valid_in`=1 toggling data -> all outputs 0 throughout. After release, `clk_f` reads 0,0,1,1,0,0,1,1.
- Single word: bytes FF,FB,BF,FF with `valid_in`=1 on 4 consecutive cycles -> `data_out`=32'hFFFBBFFF and `valid_out`=1 for exactly 4 cycles, then `valid_out`=0 with `data_out` unchanged.
- Back-to-back: DD×4 followed immediately by 00,00,00,03 -> `data_out`=32'hDDDDDDDD for 4 cycles, then 32'h00000003. `valid_out` stays high for 8 cycles with no glitch.
- Fragment: AA,AA then `valid_in`=0, then 12,34,56,78 -> one `err_frag` pulse, no `valid_out` for the AA bytes, then `data_out`=32'h12345678 with `valid_out`.
- Reset mid-word: 11,22 then `reset` for 1 cycle, then 33,44,55,66 -> `err_frag` stays 0 and `data_out`=32'h33445566.
- Serializer loopback: drive words FFFBBFFF, DDDDDDDD, (invalid AAAAAAAA), 00000003 through the 32b→8b block into this one -> received sequence is FFFBBFFF, DDDDDDDD, 00000003 with no `err_frag`.

Source files
------------

// File: rtl/conv_8b_32b.sv
// Byte-to-word packer: collects four consecutive valid bytes (MSB first) into a 32-bit word.
// It also provides a free-running divide-by-4 clock and flags discarded partial words.
module conv_8b_32b (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        clk_f,
  output logic        err_frag
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t      state_q;
  logic [1:0]  bcnt_q;
  logic [1:0]  hcnt_q;
  logic [1:0]  dcnt_q;
  logic [23:0] sreg_q;
  logic [31:0] data_q;
  logic        valid_q;
  logic        err_q;
  logic        word_done_d;

  // The fourth byte bypasses the shift register and lands straight in the output word.
  assign word_done_d = (state_q == FILL) && valid_in && (bcnt_q == 2'd3);

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q <= IDLE;
      bcnt_q  <= 2'd0;
      hcnt_q  <= 2'd0;
      dcnt_q  <= 2'd0;
      sreg_q  <= 24'h0;
      data_q  <= 32'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      dcnt_q <= dcnt_q + 2'd1;
      err_q  <= 1'b0;

      // A completion on the last hold cycle reloads the window, so valid_out never dips.
      if (word_done_d) begin
        data_q  <= {sreg_q, data_in};
        valid_q <= 1'b1;
        hcnt_q  <= 2'd3;
      end else if (hcnt_q != 2'd0) begin
        hcnt_q <= hcnt_q - 2'd1;
      end else begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (valid_in) begin
            sreg_q[23:16] <= data_in;
            bcnt_q        <= 2'd1;
            state_q       <= FILL;
          end
        end
        FILL: begin
          if (!valid_in) begin
            bcnt_q  <= 2'd0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else if (bcnt_q == 2'd3) begin
            bcnt_q  <= 2'd0;
            state_q <= IDLE;
          end else begin
            if (bcnt_q == 2'd1) begin
              sreg_q[15:8] <= data_in;
            end else begin
              sreg_q[7:0] <= data_in;
            end
            bcnt_q <= bcnt_q + 2'd1;
          end
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign clk_f     = dcnt_q[1];
  assign err_frag  = err_q;

endmodule
